sdram_resp_formatter: RTL and testbench

Downstream stage of the SDRAM interface and upstream of the UART transmitter. Captures each 16-bit read word returned by the SDRAM interface on its `valid` strobe into a small FIFO. Serialises each word as uppercase ASCII hex characters into the UART TX write port, honouring the UART's `tx_full` back-pressure. Replaces the direct `sdram_data_out[7:0]` to UART `data_in` connection, which loses the upper byte and has no buffering.

---
 rtl/sdram_resp_formatter_pkg.sv | 32 +++
 rtl/sdram_resp_formatter_fifo.sv | 68 ++++++
 rtl/sdram_resp_formatter.sv | 157 +++++++++++++++
 tb/tb_sdram_resp_formatter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_resp_formatter_pkg.sv
`default_nettype none
// ============================================================================
//  resp_pkg
//  State encoding, ASCII constants and nibble-to-hex helper for the
//  SDRAM read-response formatter.
//  Revision: 1.0
// ============================================================================
package resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_CR    = 2'd2,
    ST_LF    = 2'd3
  } resp_state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFF = 8'h37;

  // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end else begin
      return ASCII_A_OFF + {4'h0, nib};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_resp_formatter_fifo.sv
`default_nettype none
// ============================================================================
//  resp_fifo
//  Synchronous FIFO for read words; a push while full is accepted only when a
//  pop happens in the same cycle.
//  Revision: 1.0
// ============================================================================
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == c_depth);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign pop_data  = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_resp_formatter.sv
`default_nettype none
// ============================================================================
//  sdram_resp_formatter
//  Buffers SDRAM read words and prints each as ASCII hex into the UART TX.
//  Build option: RESP_CRLF_EN appends CR/LF after every word.
//  Revision: 1.0
// ============================================================================
module sdram_resp_formatter
  import resp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             data_in,
  input  logic                    valid,
  input  logic                    tx_full,
  output logic                    wr_data,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam logic [2:0] c_last_digit = 3'(DIGITS - 1);

  resp_state_t r_state;
  resp_state_t w_state_nxt;
  logic [15:0] r_shift;
  logic [15:0] w_shift_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_wr;
  logic        w_wr_nxt;
  logic [7:0]  r_tx;
  logic [7:0]  w_tx_nxt;
  logic        r_ovf;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [15:0] w_head;
  logic [15:0] w_load;
  logic        w_can_write;
  logic [$clog2(DEPTH):0] w_level;

  resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (valid),
    .push_data (data_in),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  // With two digits only the low byte is printed, so it is moved to the top.
  generate
    if (DIGITS == 2) begin : g_align_byte
      assign w_load = {w_head[7:0], 8'h00};
    end else begin : g_align_word
      assign w_load = w_head;
    end
  endgenerate

  // One idle cycle after every write lets the UART refresh tx_full.
  assign w_can_write = !tx_full && !r_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_wr_nxt    = 1'b0;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_load;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (w_can_write) begin
          w_wr_nxt    = 1'b1;
          w_tx_nxt    = hex_to_ascii(r_shift[15:12]);
          w_shift_nxt = {r_shift[11:0], 4'h0};
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == c_last_digit) begin
`ifdef RESP_CRLF_EN
            w_state_nxt = ST_CR;
`else
            w_state_nxt = ST_IDLE;
`endif
          end
        end
      end
`ifdef RESP_CRLF_EN
      ST_CR: begin
        if (w_can_write) begin
          w_wr_nxt    = 1'b1;
          w_tx_nxt    = ASCII_CR;
          w_state_nxt = ST_LF;
        end
      end
      ST_LF: begin
        if (w_can_write) begin
          w_wr_nxt    = 1'b1;
          w_tx_nxt    = ASCII_LF;
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_tx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr    <= w_wr_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // A word is lost only when full and no pop frees a slot this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (valid && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign wr_data  = r_wr;
  assign tx_data  = r_tx;
  assign overflow = r_ovf;
  assign level    = w_level;
  assign busy     = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_resp_formatter.sv
`default_nettype none
// ============================================================================
//  tb_sdram_resp_formatter
//  Self-checking bench: directed sequences, a vector table and randomized
//  traffic compared cycle by cycle against a queue-based reference model.
//  Revision: 1.0
// ============================================================================
module tb_sdram_resp_formatter;

  localparam int DEPTH = 4;
`ifdef RESP_CRLF_EN
  localparam int CRLF = 2;
`else
  localparam int CRLF = 0;
`endif
  localparam int CPW = 4 + CRLF;
  localparam logic [7:0] CH_0 = "0";
  localparam logic [7:0] CH_A = "A";

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        valid;
  logic        tx_full;
  logic        wr_data;
  logic [7:0]  tx_data;
  logic        busy;
  logic        overflow;
  logic [2:0]  level;

  logic [15:0] d2_data_in;
  logic        d2_valid;
  logic        d2_tx_full;
  logic        d2_wr;
  logic [7:0]  d2_tx;
  logic        d2_busy;
  logic        d2_ovf;
  logic [2:0]  d2_level;

  always #5 clk = ~clk;

  sdram_resp_formatter #(.DEPTH(DEPTH), .DIGITS(4)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .tx_full(tx_full), .wr_data(wr_data), .tx_data(tx_data),
    .busy(busy), .overflow(overflow), .level(level)
  );

  sdram_resp_formatter #(.DEPTH(DEPTH), .DIGITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(d2_data_in), .valid(d2_valid),
    .tx_full(d2_tx_full), .wr_data(d2_wr), .tx_data(d2_tx),
    .busy(d2_busy), .overflow(d2_ovf), .level(d2_level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: words, characters, sticky drop ----------
  logic [15:0] m_fifo[$];
  logic [7:0]  m_chars[$];
  bit          m_active;
  bit          m_wr;
  bit          m_ovf;
  logic [7:0]  m_tx;

  function automatic logic [7:0] ref_hex(input int n);
    if (n < 10) return 8'(CH_0 + n);
    return 8'(CH_A + n - 10);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_chars.delete();
    m_active = 0;
    m_wr     = 0;
    m_ovf    = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d, input bit tf);
    bit          pop;
    bit          new_wr;
    logic [15:0] w;
    pop    = !m_active && (m_fifo.size() > 0);
    new_wr = 0;
    if (m_active && !tf && !m_wr) begin
      new_wr = 1;
      m_tx   = m_chars.pop_front();
      if (m_chars.size() == 0) m_active = 0;
    end
    if (pop) begin
      w = m_fifo.pop_front();
      for (int i = 3; i >= 0; i--) m_chars.push_back(ref_hex(int'(w[i*4 +: 4])));
      if (CRLF != 0) begin
        m_chars.push_back(8'd13);
        m_chars.push_back(8'd10);
      end
      m_active = 1;
    end
    if (v) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else m_ovf = 1;
    end
    m_wr = new_wr;
  endtask

  // ---------------- monitor: capture characters, lockstep compare -------------
  logic [7:0] got_ch[$];
  int         got_cy[$];
  logic [7:0] got2[$];
  logic [7:0] exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      if (wr_data) begin
        got_ch.push_back(tx_data);
        got_cy.push_back(cyc);
      end
      if (d2_wr) got2.push_back(d2_tx);
      check("model wr_data", 32'(wr_data), 32'(m_wr));
      if (m_wr) check("model tx_data", 32'(tx_data), 32'(m_tx));
      check("model level", 32'(level), 32'(m_fifo.size()));
      check("model overflow", 32'(overflow), 32'(m_ovf));
      check("model busy", 32'(busy), 32'(m_active || (m_fifo.size() > 0)));
      if (reset) model_step(valid, data_in, tx_full);
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers -------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input logic [15:0] d);
    valid   = 1'b1;
    data_in = d;
    tick();
    valid   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || wr_data) && n < budget) begin
      tick();
      n++;
    end
    check("drain reaches idle", 32'(busy), 32'd0);
    tick(2);
  endtask

  task automatic exp_word(input logic [31:0] s);
    for (int i = 0; i < 4; i++) exp_q.push_back(s[31-8*i -: 8]);
    if (CRLF != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic clear_seq();
    got_ch.delete();
    got_cy.delete();
    exp_q.delete();
  endtask

  task automatic cmp_seq(input string name);
    check({name, " count"}, 32'(got_ch.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_ch.size(); i++)
      check(name, 32'(got_ch[i]), 32'(exp_q[i]));
  endtask

  typedef struct {
    logic [15:0] word;
    logic [31:0] text;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int push_edge;
    int cnt;
    int n;

    vecs[0] = '{16'h0000, "0000"};
    vecs[1] = '{16'hFFFF, "FFFF"};
    vecs[2] = '{16'h9A5B, "9A5B"};
    vecs[3] = '{16'h5678, "5678"};
    vecs[4] = '{16'hABCD, "ABCD"};
    vecs[5] = '{16'hE0F1, "E0F1"};
    vecs[6] = '{16'h09AF, "09AF"};

    reset = 1'b0; valid = 1'b0; data_in = '0; tx_full = 1'b0;
    d2_valid = 1'b0; d2_data_in = '0; d2_tx_full = 1'b0;

    // Reset state
    tick(3);
    check("reset wr_data", 32'(wr_data), 0);
    check("reset tx_data", 32'(tx_data), 0);
    check("reset busy", 32'(busy), 0);
    check("reset overflow", 32'(overflow), 0);
    check("reset level", 32'(level), 0);
    reset = 1'b1;
    tick(2);

    // Single word with latency and spacing
    clear_seq();
    exp_q = '{8'h31, 8'h41, 8'h32, 8'h46};
    if (CRLF != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    valid = 1'b1; data_in = 16'h1A2F; push_edge = cyc + 1;
    tick();
    valid = 1'b0;
    check("single level after push", 32'(level), 1);
    wait_idle(200);
    cmp_seq("single seq");
    if (got_cy.size() > 0) check("single first latency", 32'(got_cy[0] - push_edge), 2);
    for (int i = 1; i < got_cy.size(); i++)
      check("single spacing", 32'(got_cy[i] - got_cy[i-1]), 2);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      clear_seq();
      exp_word(vecs[v].text);
      push1(vecs[v].word);
      wait_idle(200);
      cmp_seq("table seq");
    end

    // Back-pressure after the second character
    clear_seq();
    exp_word("C0DE");
    push1(16'hC0DE);
    n = 0;
    while (got_ch.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    check("bp two chars", 32'(got_ch.size()), 2);
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp no write", 32'(wr_data), 0);
      check("bp busy", 32'(busy), 1);
    end
    check("bp nothing emitted", 32'(got_ch.size()), 2);
    tx_full = 1'b0;
    wait_idle(200);
    cmp_seq("bp seq");

    // Push arriving in the pop cycle with the FIFO full
    clear_seq();
    tx_full = 1'b1;
    valid   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 16'hA000 + 16'(i);
      tick();
    end
    valid = 1'b0;
    tick();
    check("pp level full", 32'(level), 4);
    check("pp overflow", 32'(overflow), 0);
    tx_full = 1'b0;
    cnt = 0; n = 0;
    while (cnt < CPW && n < 200) begin
      tick();
      n++;
      if (wr_data) cnt++;
    end
    check("pp first word", 32'(cnt), 32'(CPW));
    push1(16'hA006);
    check("pp level kept", 32'(level), 4);
    check("pp no drop", 32'(overflow), 0);
    wait_idle(500);
    exp_word("A001"); exp_word("A002"); exp_word("A003");
    exp_word("A004"); exp_word("A005"); exp_word("A006");
    cmp_seq("pp seq");

    // Overflow: one word sits in the shift register, four in the FIFO
    clear_seq();
    tx_full = 1'b1;
    valid   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 16'(i);
      tick();
    end
    valid = 1'b0;
    tick();
    check("ovf level 5 pushes", 32'(level), 4);
    check("ovf not yet", 32'(overflow), 0);
    push1(16'h0006);
    check("ovf level", 32'(level), 4);
    check("ovf set", 32'(overflow), 1);
    tx_full = 1'b0;
    wait_idle(500);
    exp_word("0001"); exp_word("0002"); exp_word("0003");
    exp_word("0004"); exp_word("0005");
    cmp_seq("ovf seq");
    check("ovf sticky", 32'(overflow), 1);

    // Reset mid-word
    clear_seq();
    push1(16'hBEEF);
    cnt = 0; n = 0;
    while (cnt < 2 && n < 50) begin
      tick();
      n++;
      if (wr_data) cnt++;
    end
    check("rst two chars", 32'(cnt), 2);
    reset = 1'b0;
    #1;
    check("rst wr_data", 32'(wr_data), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst busy", 32'(busy), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst level", 32'(level), 0);
    tick(2);
    reset = 1'b1;
    clear_seq();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post-rst quiet", 32'(wr_data), 0);
      check("post-rst busy", 32'(busy), 0);
    end
    check("post-rst chars", 32'(got_ch.size()), 0);

    // Two-digit instance prints only the low byte
    got2.delete();
    d2_valid = 1'b1; d2_data_in = 16'h12C9;
    tick();
    d2_valid = 1'b0;
    n = 0;
    while (d2_busy && n < 100) begin
      tick();
      n++;
    end
    tick(2);
    check("d2 count", 32'(got2.size()), 32'(2 + CRLF));
    if (got2.size() >= 2) begin
      check("d2 char0", 32'(got2[0]), 32'h43);
      check("d2 char1", 32'(got2[1]), 32'h39);
    end
    if (got2.size() >= 4) begin
      check("d2 cr", 32'(got2[2]), 32'h0D);
      check("d2 lf", 32'(got2[3]), 32'h0A);
    end
    check("d2 busy", 32'(d2_busy), 0);

    // Randomized traffic at three push rates; the model checks every cycle
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1000; i++) begin
        valid   = ($urandom_range(0, 99) < (p == 0 ? 5 : (p == 1 ? 20 : 60)));
        data_in = 16'($urandom);
        tx_full = ($urandom_range(0, 99) < 30);
        tick();
      end
      valid   = 1'b0;
      tx_full = 1'b0;
      wait_idle(500);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
